noc_pipe_array: RTL and testbench

Parametrised, flow-controlled channel array between FPGA fabric ports and the NoC router nodes. Each of NODES independent channels carries WIDTH-bit flits across PIPE_STAGES register stages, which close timing on long fabric-to-router wires. Each channel uses credit-based backpressure into a FIFO_DEPTH-entry receive FIFO. Per-channel flit counters and a sticky overflow flag support bring-up and verification.

---
 rtl/noc_pipe_pkg.sv | 17 +
 rtl/noc_pipe_channel.sv | 108 ++++++++++
 rtl/noc_pipe_array.sv | 61 ++++++
 tb/tb_noc_pipe_array.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pipe_pkg.sv
// Shared constants and sizing helpers for the NoC channel pipe array.
package noc_pipe_pkg;

    localparam int MAX_WIDTH       = 800;
    localparam int MAX_PIPE_STAGES = 8;

    // Credit counter must hold every value from 0 up to the FIFO depth.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Smallest receive FIFO that covers the full credit round trip.
    function automatic int min_full_rate_depth(input int stages);
        return 2 * stages + 2;
    endfunction

endpackage

// File: rtl/noc_pipe_channel.sv
// One credit-flow-controlled channel: forward register pipeline, credit
// return pipeline, receive FIFO, handshake counter and sticky overflow flag.
module noc_pipe_channel
    import noc_pipe_pkg::*;
#(
    parameter int WIDTH       = 600,
    parameter int PIPE_STAGES = 2,
    parameter int FIFO_DEPTH  = 6,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [WIDTH-1:0]       out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    input  logic                   clr_counts_i,
    output logic [COUNT_WIDTH-1:0] flit_count_o,
    output logic                   overflow_o
);

    localparam int                CRED_W   = credit_width(FIFO_DEPTH);
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] DEPTH_C  = CRED_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [PIPE_STAGES-1:0] fwd_vld_q;
    logic [WIDTH-1:0]       fwd_dat_q [PIPE_STAGES];
    // One slot longer than the forward valids: the forward side spends its
    // last edge writing the FIFO, so both directions take PIPE_STAGES+1 edges.
    logic [PIPE_STAGES:0]   ret_q;
    logic [CRED_W-1:0]      credit_q, credit_d;
    logic [CRED_W-1:0]      occ_q, occ_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0]       mem_q [FIFO_DEPTH];
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   overflow_q;

    logic accept, pop, wr_req, full, wr_en, credit_in;

    // Pointers wrap at the last real entry; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready_o   = (credit_q != '0);
    assign accept       = in_valid_i && in_ready_o;
    assign out_valid_o  = (occ_q != '0);
    assign pop          = out_valid_o && out_ready_i;
    assign wr_req       = fwd_vld_q[PIPE_STAGES-1];
    assign full         = (occ_q == DEPTH_C);
    assign wr_en        = wr_req && !full;
    assign credit_in    = ret_q[PIPE_STAGES];
    assign out_data_o   = mem_q[rd_ptr_q];
    assign flit_count_o = count_q;
    assign overflow_o   = overflow_q;

    // Credit and occupancy next state; a simultaneous +1 and -1 cancel.
    // NOTE: every output gets a default first, so no path leaves a latch.
    always_comb begin
        credit_d = credit_q;
        if (accept && !credit_in)      credit_d = credit_q - CRED_W'(1);
        else if (credit_in && !accept) credit_d = credit_q + CRED_W'(1);
        occ_d = occ_q;
        if (wr_en && !pop)      occ_d = occ_q + CRED_W'(1);
        else if (pop && !wr_en) occ_d = occ_q - CRED_W'(1);
    end

    // Control state: valids, credit tokens, counters, pointers and flags.
    // NOTE: state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_vld_q  <= '0;
            ret_q      <= '0;
            credit_q   <= DEPTH_C;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            fwd_vld_q[0] <= accept;
            for (int s = 1; s < PIPE_STAGES; s++) fwd_vld_q[s] <= fwd_vld_q[s-1];
            ret_q[0] <= pop;
            for (int s = 1; s <= PIPE_STAGES; s++) ret_q[s] <= ret_q[s-1];
            credit_q <= credit_d;
            occ_q    <= occ_d;
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (clr_counts_i) count_q <= '0;
            else if (pop)     count_q <= count_q + COUNT_WIDTH'(1);
            if (wr_req && full) overflow_q <= 1'b1;
        end
    end

    // Flit data and FIFO storage load only on a valid beat, so idle cycles do not toggle.
    // NOTE: no reset on data or memory; the valid bits and occupancy qualify every read.
    always_ff @(posedge clk) begin
        if (accept) fwd_dat_q[0] <= in_data_i;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            if (fwd_vld_q[s-1]) fwd_dat_q[s] <= fwd_dat_q[s-1];
        end
        if (wr_en) mem_q[wr_ptr_q] <= fwd_dat_q[PIPE_STAGES-1];
    end

endmodule

// File: rtl/noc_pipe_array.sv
// Array of NODES independent credit-flow-controlled channels between fabric
// ports and NoC router nodes.
module noc_pipe_array
    import noc_pipe_pkg::*;
#(
    parameter int WIDTH       = 600,
    parameter int NODES       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int FIFO_DEPTH  = 6,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data    [0:NODES-1],
    input  logic [NODES-1:0]       in_valid,
    output logic [NODES-1:0]       in_ready,
    output logic [WIDTH-1:0]       out_data   [0:NODES-1],
    output logic [NODES-1:0]       out_valid,
    input  logic [NODES-1:0]       out_ready,
    input  logic                   clr_counts,
    output logic [COUNT_WIDTH-1:0] flit_count [0:NODES-1],
    output logic [NODES-1:0]       overflow
);

    // Reject illegal configurations at elaboration.
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("noc_pipe_array: WIDTH out of range 1..%0d", MAX_WIDTH);
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
        $error("noc_pipe_array: PIPE_STAGES out of range 1..%0d", MAX_PIPE_STAGES);
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64) begin : g_bad_depth
        $error("noc_pipe_array: FIFO_DEPTH out of range 2..64");
    end
    if (NODES < 1 || COUNT_WIDTH < 1) begin : g_bad_sizes
        $error("noc_pipe_array: NODES and COUNT_WIDTH must be at least 1");
    end

    // One self-contained channel per node; no shared arbitration.
    for (genvar n = 0; n < NODES; n++) begin : g_chan
        noc_pipe_channel #(
            .WIDTH       (WIDTH),
            .PIPE_STAGES (PIPE_STAGES),
            .FIFO_DEPTH  (FIFO_DEPTH),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .in_data_i    (in_data[n]),
            .in_valid_i   (in_valid[n]),
            .in_ready_o   (in_ready[n]),
            .out_data_o   (out_data[n]),
            .out_valid_o  (out_valid[n]),
            .out_ready_i  (out_ready[n]),
            .clr_counts_i (clr_counts),
            .flit_count_o (flit_count[n]),
            .overflow_o   (overflow[n])
        );
    end

endmodule

// File: tb/tb_noc_pipe_array.sv
// Self-checking bench for noc_pipe_array: random and directed traffic with a
// timing-level reference model and per-channel scoreboards.
`timescale 1ns/1ps
module tb_noc_pipe_array;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int PS = 2;
    localparam int D  = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  in_data    [0:N-1];
    logic [N-1:0]  in_valid   = '0;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data   [0:N-1];
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready  = '0;
    logic          clr_counts = 1'b0;
    logic [CW-1:0] flit_count [0:N-1];
    logic [N-1:0]  overflow;

    noc_pipe_array #(
        .WIDTH(W), .NODES(N), .PIPE_STAGES(PS), .FIFO_DEPTH(D), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .clr_counts(clr_counts), .flit_count(flit_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Edge index: value k means k rising edges have occurred.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each accepted flit becomes visible at the head once
    // its write edge has passed; each pop returns one credit PS+1 edges later.
    typedef struct {
        logic [W-1:0] data;
        int           due;
    } flit_t;

    flit_t exp_q [N][$];
    int    ret_q [N][$];
    int    outstanding [N];
    int    exp_cnt [N];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s ch%0d: got %0h expected %0h (t=%0t)", name, ch, act, exp, $time);
    endtask

    // Monitor: mid-cycle, compare DUT outputs with the model, then record the
    // handshakes that the coming edge will perform.
    initial begin : monitor
        bit exp_rdy, exp_vld;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    exp_q[i].delete();
                    ret_q[i].delete();
                    outstanding[i] = 0;
                    exp_cnt[i]     = 0;
                    check("rst_in_ready",   i, 64'(in_ready[i]),   64'(1));
                    check("rst_out_valid",  i, 64'(out_valid[i]),  64'(0));
                    check("rst_flit_count", i, 64'(flit_count[i]), 64'(0));
                    check("rst_overflow",   i, 64'(overflow[i]),   64'(0));
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    while (ret_q[i].size() > 0 && ret_q[i][0] <= cyc) begin
                        void'(ret_q[i].pop_front());
                        outstanding[i]--;
                    end
                    exp_rdy = (outstanding[i] < D);
                    exp_vld = (exp_q[i].size() > 0) && (exp_q[i][0].due <= cyc);
                    check("in_ready",   i, 64'(in_ready[i]),   64'(exp_rdy));
                    check("out_valid",  i, 64'(out_valid[i]),  64'(exp_vld));
                    check("flit_count", i, 64'(flit_count[i]), 64'(exp_cnt[i]));
                    check("overflow",   i, 64'(overflow[i]),   64'(0));
                    if (exp_vld && out_ready[i]) begin
                        check("out_data", i, 64'(out_data[i]), 64'(exp_q[i][0].data));
                        void'(exp_q[i].pop_front());
                        ret_q[i].push_back(cyc + PS + 2);
                        exp_cnt[i] = (exp_cnt[i] + 1) % (1 << CW);
                    end
                    if (clr_counts) exp_cnt[i] = 0;
                    if (in_valid[i] && exp_rdy) begin
                        exp_q[i].push_back('{data: in_data[i], due: cyc + 1 + PS});
                        outstanding[i]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        in_valid  = '0;
        out_ready = '1;
        repeat (cycles) tick();
    endtask

    // Stream n flits on channel ch, holding valid until each is taken.
    task automatic stream(input int ch, input int n, input logic [W-1:0] base);
        int sent  = 0;
        int guard = 0;
        bit took;
        while (sent < n && guard < 1000) begin
            in_data[ch]  = base + W'(sent);
            in_valid[ch] = 1'b1;
            took = in_ready[ch];
            tick();
            if (took) sent++;
            guard++;
        end
        in_valid[ch] = 1'b0;
        check("stream_sent", ch, 64'(sent), 64'(n));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int guard;
        int pv, pr;
        for (int i = 0; i < N; i++) in_data[i] = '0;

        // Reset held with valid asserted: inputs ignored, FIFOs stay empty.
        rst = 1'b0;
        in_valid = '1;
        for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
        repeat (5) tick();
        in_valid = '0;
        rst = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < N; i++) check("post_rst_out_valid", i, 64'(out_valid[i]), 64'(0));

        // Single flit on channel 3: visible after edge E+2, credit back at E+6.
        out_ready = '1;
        repeat (2) tick();
        in_data[3]  = 16'h00A5;
        in_valid[3] = 1'b1;
        tick();                                  // edge E
        in_valid[3] = 1'b0;
        check("single_valid_e0",  3, 64'(out_valid[3]), 64'(0));
        check("single_credit_e0", 3, 64'(dut.g_chan[3].u_chan.credit_q), 64'(D - 1));
        tick();                                  // E+1
        check("single_valid_e1",  3, 64'(out_valid[3]), 64'(0));
        tick();                                  // E+2
        check("single_valid_e2",  3, 64'(out_valid[3]), 64'(1));
        check("single_data_e2",   3, 64'(out_data[3]),  64'(16'h00A5));
        tick();                                  // E+3: popped
        check("single_count_e3",  3, 64'(flit_count[3]), 64'(1));
        tick();
        tick();                                  // E+5
        check("single_credit_e5", 3, 64'(dut.g_chan[3].u_chan.credit_q), 64'(D - 1));
        tick();                                  // E+6
        check("single_credit_e6", 3, 64'(dut.g_chan[3].u_chan.credit_q), 64'(D));

        // Long stream with the router always ready.
        stream(0, 100, 16'h1000);
        drain(20);

        // Backpressure: exactly D flits taken, then the channel stalls.
        out_ready = '0;
        in_valid  = '1;
        for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
        repeat (20) begin
            tick();
            for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            check("bp_in_ready",  i, 64'(in_ready[i]),  64'(0));
            check("bp_out_valid", i, 64'(out_valid[i]), 64'(1));
        end
        in_valid  = '0;
        out_ready = '1;
        tick();                                  // first pop at edge P
        check("bp_ready_p0", 0, 64'(in_ready[0]), 64'(0));
        tick();
        check("bp_ready_p1", 0, 64'(in_ready[0]), 64'(0));
        tick();
        check("bp_ready_p2", 0, 64'(in_ready[0]), 64'(0));
        tick();
        check("bp_ready_p3", 0, 64'(in_ready[0]), 64'(1));
        drain(20);

        // Random traffic on all channels with varying load and occasional clears.
        for (int epoch = 0; epoch < 10; epoch++) begin
            pv = $urandom_range(1, 4);
            pr = $urandom_range(1, 4);
            repeat (1000) begin
                for (int i = 0; i < N; i++) begin
                    in_valid[i]  = ($urandom_range(0, 4) < pv);
                    out_ready[i] = ($urandom_range(0, 4) < pr);
                    in_data[i]   = W'($urandom);
                end
                clr_counts = ($urandom_range(0, 63) == 0);
                tick();
            end
        end
        clr_counts = 1'b0;
        drain(30);

        // Counter wrap: 17 handshakes on a 4-bit counter leave 1.
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        stream(5, 17, 16'h5000);
        repeat (15) tick();
        check("wrap_count", 5, 64'(flit_count[5]), 64'(1));

        // Clear on the same edge as a handshake wins.
        out_ready[5] = 1'b0;
        stream(5, 1, 16'h5A5A);
        guard = 0;
        while (!out_valid[5] && guard < 20) begin
            tick();
            guard++;
        end
        check("clr_wait_valid", 5, 64'(out_valid[5]), 64'(1));
        out_ready[5] = 1'b1;
        clr_counts   = 1'b1;
        tick();
        clr_counts = 1'b0;
        check("clr_on_pop_count", 5, 64'(flit_count[5]), 64'(0));
        check("clr_on_pop_empty", 5, 64'(out_valid[5]), 64'(0));

        // Reset pulse mid-stream discards every in-flight flit and credit.
        repeat (30) begin
            for (int i = 0; i < N; i++) begin
                in_valid[i]  = 1'b1;
                out_ready[i] = ($urandom_range(0, 3) == 0);
                in_data[i]   = W'($urandom);
            end
            tick();
        end
        rst = 1'b0;
        repeat (2) tick();
        in_valid = '0;
        rst = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < N; i++) begin
            check("midrst_out_valid", i, 64'(out_valid[i]), 64'(0));
            check("midrst_in_ready",  i, 64'(in_ready[i]),  64'(1));
        end

        // Short random burst after reset, then final drain.
        repeat (200) begin
            for (int i = 0; i < N; i++) begin
                in_valid[i]  = ($urandom_range(0, 1) == 0);
                out_ready[i] = ($urandom_range(0, 2) != 0);
                in_data[i]   = W'($urandom);
            end
            tick();
        end
        drain(30);
        for (int i = 0; i < N; i++) check("final_empty", i, 64'(exp_q[i].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
